// File: rtl/matmul_sequencer.sv
// Address/control sequencer for a single-MAC matrix multiplier.
// It walks the result matrix in row-major order. For each output element it
// issues K multiply-accumulate cycles and then one result-write cycle.
// Every address comes from an incrementing pointer, so no multipliers are needed.
module matmul_sequencer #(
    parameter int ROW_MAX   = 8,
    parameter int INNER_MAX = 8,
    parameter int COL_MAX   = 8
) (
    input  logic       i_wb_clk,
    input  logic       i_wb_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [7:0] i_m,
    input  logic [7:0] i_k,
    input  logic [7:0] i_n,
    output logic [7:0] o_fm_adr,
    output logic [7:0] o_sm_adr,
    output logic [7:0] o_t_adr,
    output logic       o_mac_en,
    output logic       o_acc_load,
    output logic       o_t_we,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    // Start-edge detection. "armed" stays low after reset until i_start has
    // been seen low, so a level held high through reset release is not a start.
    logic start_q;
    logic armed;
    logic err_q;

    // Job dimensions, captured when a start is accepted.
    logic [7:0] m_q, k_q, n_q;

    // Loop counters for row i, column j and inner index k.
    logic [7:0] i_cnt, j_cnt, k_cnt;

    // Address pointers. row_base tracks i*K.
    // fm_ptr tracks i*K+k, sm_ptr tracks k*N+j and t_ptr tracks i*N+j.
    logic [7:0] row_base;
    logic [7:0] fm_ptr, sm_ptr, t_ptr;

    logic start_ok, dims_ok, last_k, last_j, last_i;

    // Accept a start only on a fresh rising edge while not running.
    assign start_ok = i_start && !start_q && armed && (state == IDLE || state == DONE);

    assign last_k = (k_cnt == k_q - 8'd1);
    assign last_j = (j_cnt == n_q - 8'd1);
    assign last_i = (i_cnt == m_q - 8'd1);

    // Dimension legality check on the live inputs at the moment of start.
    always_comb begin
        dims_ok = (i_m != 8'd0) && (i_k != 8'd0) && (i_n != 8'd0)
               && (int'(i_m) <= ROW_MAX)
               && (int'(i_k) <= INNER_MAX)
               && (int'(i_n) <= COL_MAX)
               && (int'(i_m) * int'(i_k) <= 256)
               && (int'(i_k) * int'(i_n) <= 256)
               && (int'(i_m) * int'(i_n) <= 256);
    end

    // State register.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!i_wb_rst_n) state <= IDLE;
        else             state <= state_nx;
    end

    // Next-state logic. Abort takes priority over completion.
    always_comb begin
        // NOTE: default first so no path leaves state_nx unassigned (no latch).
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (start_ok) state_nx = dims_ok ? MAC : DONE;
            end
            MAC: begin
                if (i_abort)     state_nx = IDLE;
                else if (last_k) state_nx = WRITE;
            end
            WRITE: begin
                if (i_abort)               state_nx = IDLE;
                else if (last_j && last_i) state_nx = DONE;
                else                       state_nx = MAC;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode. Addresses read as zero whenever they are not in use.
    always_comb begin
        o_fm_adr   = 8'd0;
        o_sm_adr   = 8'd0;
        o_t_adr    = 8'd0;
        o_mac_en   = 1'b0;
        o_acc_load = 1'b0;
        o_t_we     = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_err      = err_q;
        unique case (state)
            MAC: begin
                o_busy     = 1'b1;
                o_mac_en   = 1'b1;
                o_fm_adr   = fm_ptr;
                o_sm_adr   = sm_ptr;
                o_acc_load = (k_cnt == 8'd0);
            end
            WRITE: begin
                o_busy  = 1'b1;
                o_t_adr = t_ptr;
                o_t_we  = !i_abort;
            end
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    // Start-edge history and the error flag.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            start_q <= 1'b0;
            armed   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= i_start;
            armed   <= armed | ~i_start;
            if (start_ok) err_q <= !dims_ok;
        end
    end

    // Dimension latches, loop counters and address pointers.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            m_q      <= 8'd0;
            k_q      <= 8'd0;
            n_q      <= 8'd0;
            i_cnt    <= 8'd0;
            j_cnt    <= 8'd0;
            k_cnt    <= 8'd0;
            row_base <= 8'd0;
            fm_ptr   <= 8'd0;
            sm_ptr   <= 8'd0;
            t_ptr    <= 8'd0;
        end else if (start_ok) begin
            if (dims_ok) begin
                m_q <= i_m;
                k_q <= i_k;
                n_q <= i_n;
            end
            i_cnt    <= 8'd0;
            j_cnt    <= 8'd0;
            k_cnt    <= 8'd0;
            row_base <= 8'd0;
            fm_ptr   <= 8'd0;
            sm_ptr   <= 8'd0;
            t_ptr    <= 8'd0;
        end else if (!i_abort) begin
            if (state == MAC && !last_k) begin
                k_cnt  <= k_cnt + 8'd1;
                fm_ptr <= fm_ptr + 8'd1;
                sm_ptr <= sm_ptr + n_q;
            end else if (state == WRITE) begin
                t_ptr <= t_ptr + 8'd1;
                k_cnt <= 8'd0;
                if (last_j) begin
                    j_cnt  <= 8'd0;
                    sm_ptr <= 8'd0;
                    if (!last_i) begin
                        i_cnt    <= i_cnt + 8'd1;
                        row_base <= row_base + k_q;
                        fm_ptr   <= row_base + k_q;
                    end
                end else begin
                    j_cnt  <= j_cnt + 8'd1;
                    fm_ptr <= row_base;
                    sm_ptr <= j_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard testbench for matmul_sequencer. The stimulus pushes the expected
// MAC/write events, and a negedge monitor pops and compares them as they appear.
module tb_matmul_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start, i_abort;
    logic [7:0] i_m, i_k, i_n;
    logic [7:0] o_fm_adr, o_sm_adr, o_t_adr;
    logic       o_mac_en, o_acc_load, o_t_we, o_busy, o_done, o_err;

    typedef struct packed {
        logic       we;
        logic [7:0] a;
        logic [7:0] b;
        logic       load;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_m        (i_m),
        .i_k        (i_k),
        .i_n        (i_n),
        .o_fm_adr   (o_fm_adr),
        .o_sm_adr   (o_sm_adr),
        .o_t_adr    (o_t_adr),
        .o_mac_en   (o_mac_en),
        .o_acc_load (o_acc_load),
        .o_t_we     (o_t_we),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {2'b00, o_fm_adr, o_sm_adr, o_t_adr, o_mac_en, o_acc_load,
                o_t_we, o_busy, o_done, o_err};
    endfunction

    // Queue the events of a job: full elements (K MACs and one write) up to
    // n_writes, then extra_macs MACs of the next element.
    task automatic push_job(input int m, input int k, input int n,
                            input int n_writes, input int extra_macs);
        int e;
        e = 0;
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                if (e <= n_writes) begin
                    for (int kk = 0; kk < k; kk++) begin
                        if (e < n_writes || kk < extra_macs)
                            exp_q.push_back('{we: 1'b0, a: 8'(r * k + kk),
                                              b: 8'(kk * n + c), load: (kk == 0)});
                    end
                    if (e < n_writes)
                        exp_q.push_back('{we: 1'b1, a: 8'(r * n + c), b: 8'd0, load: 1'b0});
                end
                e++;
            end
        end
    endtask

    // Monitor: every MAC or write cycle must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (o_mac_en || o_t_we)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {13'd0, o_t_we, o_t_adr, o_fm_adr, o_sm_adr, o_acc_load}, 32'd0);
            end else begin
                ev_t e;
                ev_t got;
                e   = exp_q.pop_front();
                got = '{we: o_t_we,
                        a: o_t_we ? o_t_adr : o_fm_adr,
                        b: o_mac_en ? o_sm_adr : 8'd0,
                        load: o_acc_load};
                check(e.we ? "write_event" : "mac_event", 32'(got), 32'(e));
            end
        end
    end

    // Run one legal job to completion. With disturb set, a second start edge
    // is raised and the dimensions are changed while the job is busy.
    task automatic run_job(input int m, input int k, input int n, input bit disturb);
        int cycles;
        push_job(m, k, n, m * n, 0);
        i_m = 8'(m); i_k = 8'(k); i_n = 8'(n);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("start_clears_err", {31'd0, o_err}, 32'd0);
        cycles = 0;
        while (o_busy && cycles < 2000) begin
            cycles++;
            if (disturb && cycles == 4) begin
                i_start = 1'b1; i_m = 8'd5; i_k = 8'd1; i_n = 8'd7;
            end
            if (disturb && cycles == 6) i_start = 1'b0;
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(cycles), 32'(m * n * (k + 1)));
        check("done_err", {30'd0, o_done, o_err}, 32'h2);
        check("idle_addrs", {8'd0, o_fm_adr, o_sm_adr, o_t_adr}, 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        check("done_held", {30'd0, o_done, o_busy}, 32'h2);
    endtask

    // An illegal start: DONE with error, no MAC or write activity.
    task automatic run_bad(input int m, input int k, input int n);
        i_m = 8'(m); i_k = 8'(k); i_n = 8'(n);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("bad_status", {29'd0, o_busy, o_done, o_err}, 32'h3);
        @(posedge clk); #1;
        check("bad_quiet", {30'd0, o_mac_en, o_t_we}, 32'd0);
        check("bad_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_m = 8'd0; i_k = 8'd0; i_n = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", {30'd0, o_busy, o_done}, 32'd0);

        // 2x3x2 job: 16 busy cycles, writes at 0..3.
        run_job(2, 3, 2, 1'b0);

        // Abort while in DONE is ignored.
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check("abort_in_done", {30'd0, o_done, o_busy}, 32'h2);

        // Minimal 1x1x1 job.
        run_job(1, 1, 1, 1'b0);

        // Illegal dimensions, then a legal start clears the error.
        run_bad(2, 9, 2);
        run_bad(0, 3, 2);
        run_job(1, 1, 1, 1'b0);

        // Second start edge and dimension change during a job are ignored.
        run_job(2, 3, 2, 1'b1);

        // Other shapes, including the maximum size.
        run_job(3, 2, 4, 1'b0);
        run_job(8, 8, 8, 1'b0);

        // Abort during the third write of a 2x3x2 job.
        push_job(2, 3, 2, 2, 3);
        i_m = 8'd2; i_k = 8'd3; i_n = 8'd2;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (o_t_we && o_t_adr == 8'd2) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("abort_write_reached", {31'd0, found}, 32'd1);
        if (found) begin
            #1 i_abort = 1'b1;
            #1 check("abort_suppresses_we", {31'd0, o_t_we}, 32'd0);
            @(posedge clk); #1;
            i_abort = 1'b0;
            check("abort_to_idle", {29'd0, o_busy, o_done, o_mac_en}, 32'd0);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort_queue", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of MAC, with i_start held high through release.
        push_job(2, 3, 2, 0, 2);
        i_m = 8'd2; i_k = 8'd3; i_n = 8'd2;
        i_start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1 check("async_reset_outputs", all_outputs(), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("no_start_after_release", {30'd0, o_busy, o_mac_en}, 32'd0);
        check("reset_queue", 32'(exp_q.size()), 32'd0);
        i_start = 1'b0;
        @(posedge clk); #1;
        run_job(2, 3, 2, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter ROW_MAX, default 8, max rows of first matrix (M).
REQ-002 SHALL have parameter INNER_MAX, default 8, max columns of first matrix / rows of second (K).
REQ-003 SHALL have parameter COL_MAX, default 8, max columns of second matrix (N).
REQ-004 SHALL have port i_wb_clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_wb_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  in  1  start request, sampled on rising edge of level.
REQ-007 SHALL have port i_abort  in  1  synchronous abort of a running job.
REQ-008 SHALL have port i_m / i_k / i_n  in  8 each  matrix dimensions M, K, N.
REQ-009 SHALL have port o_fm_adr  out  8  first-matrix read address.
REQ-010 SHALL have port o_sm_adr  out  8  second-matrix read address.
REQ-011 SHALL have port o_t_adr  out  8  result-matrix write address.
REQ-012 SHALL have port o_mac_en  out  1  MAC enable to datapath.
REQ-013 SHALL have port o_acc_load  out  1  with o_mac_en: acc <= a*b instead of acc += a*b.
REQ-014 SHALL have port o_t_we  out  1  result write strobe; acc valid this cycle.
REQ-015 SHALL have port o_busy / o_done / o_err  out  1 each  status.

Function
REQ-016 SHALL use states IDLE, MAC, WRITE, DONE.
REQ-017 SHALL detect start as i_start high while previous-cycle i_start low; edges in non-IDLE states ignored.
REQ-018 SHALL latch i_m, i_k, i_n on accepted start; later changes have no effect on the job.
REQ-019 SHALL on start with any dimension 0, or M>ROW_MAX, K>INNER_MAX, N>COL_MAX, or M*K, K*N, M*N >256: go to DONE, set o_err, issue no o_mac_en/o_t_we.
REQ-020 SHALL on valid start clear o_done/o_err, reset i,j,k to 0, enter MAC next cycle.
REQ-021 SHALL in MAC drive o_mac_en=1, o_fm_adr=i*K+k, o_sm_adr=k*N+j, o_acc_load=(k==0).
REQ-022 SHALL derive addresses from incrementing row/column base registers, no multipliers.
REQ-023 SHALL in MAC increment k; when k==K-1 go to WRITE.
REQ-024 SHALL in WRITE drive o_t_we=1, o_t_adr=i*N+j, o_mac_en=0 for exactly one cycle.
REQ-025 SHALL after WRITE advance j; when j wraps past N-1 reset j to 0 and advance i; after writing (M-1,N-1) go to DONE, else MAC with k=0.
REQ-026 SHALL produce exactly M*N*(K+1) cycles in MAC+WRITE per valid job; writes in row-major order 0..M*N-1.
REQ-027 SHALL in DONE hold o_done=1 until next accepted start; o_busy=0; return to IDLE behaviour for start acceptance.
REQ-028 SHALL hold o_busy=1 in MAC and WRITE only.
REQ-029 SHALL on i_abort in MAC or WRITE go to IDLE next edge, suppressing o_t_we that cycle; o_done stays 0; i_abort in IDLE/DONE ignored.
REQ-030 SHALL give i_abort priority over completion in the same cycle.
REQ-031 SHALL hold o_fm_adr, o_sm_adr, o_t_adr at 0 outside MAC/WRITE.

Reset
REQ-032 SHALL on i_wb_rst_n low immediately force IDLE and all outputs 0, counters 0, start-edge register 0, regardless of state.
REQ-033 SHALL after release accept a start only on a new rising edge of i_start (i_start high at release not a start).

Verification
REQ-034 SHALL pass: M=2,K=3,N=2, start -> 16 busy cycles; o_t_we at t_adr 0,1,2,3; first MAC fm/sm = (0,0),(1,2),(2,4); o_acc_load only at k=0; o_done=1, o_err=0.
REQ-035 SHALL pass: M=K=N=1 -> one MAC (acc_load=1, adrs 0,0), one WRITE t_adr 0, o_done next cycle.
REQ-036 SHALL pass: K=9 or M=0 -> no mac_en/t_we, o_done=1, o_err=1; next valid start clears o_err.
REQ-037 SHALL pass: abort during third WRITE of 2x3x2 job -> no write at t_adr 2, IDLE next cycle, o_done=0, o_busy=0.
REQ-038 SHALL pass: reset asserted mid-MAC -> outputs 0 asynchronously; i_start held high through release -> no job until low-high toggle.
REQ-039 SHALL pass: second start edge and dimension change during busy job -> ignored, original 16-cycle sequence unchanged.
